// File: rtl/floor_scheduler.sv
// floor_scheduler: owns the eight scrolling floor slots of the slime game.
// Scrolls live floors down on ceiling ticks, retires floors that leave the
// screen, and respawns one slot per scan sweep at an LFSR-chosen x position.
module floor_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_vga,
  input  logic       hit_ceiling,
  input  logic       slime_die,
  output logic [9:0] floor_pos_x0,
  output logic [9:0] floor_pos_x1,
  output logic [9:0] floor_pos_x2,
  output logic [9:0] floor_pos_x3,
  output logic [9:0] floor_pos_x4,
  output logic [9:0] floor_pos_x5,
  output logic [9:0] floor_pos_x6,
  output logic [9:0] floor_pos_x7,
  output logic [9:0] floor_pos_y0,
  output logic [9:0] floor_pos_y1,
  output logic [9:0] floor_pos_y2,
  output logic [9:0] floor_pos_y3,
  output logic [9:0] floor_pos_y4,
  output logic [9:0] floor_pos_y5,
  output logic [9:0] floor_pos_y6,
  output logic [9:0] floor_pos_y7,
  output logic [7:0] enable,
  output logic [9:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {PLAY = 2'd0, SCAN = 2'd1, DEAD = 2'd2} state_t;

  localparam logic [9:0] Y_LIMIT   = 10'd480;
  localparam logic [9:0] Y_HOLD    = 10'd479;
  localparam logic [9:0] SPAWN_GAP = 10'd50;
  localparam logic [9:0] X_RANGE   = 10'd580;
  localparam logic [9:0] SCORE_MAX = 10'd999;
  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  // Fibonacci LFSR for x^10 + x^7 + 1: taps at bits 9 and 6, shift left.
  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  // Fold the 10-bit LFSR value into the 0..579 range; 1023-580 stays in range.
  function automatic logic [9:0] fold_x(input logic [9:0] v);
    return (v < X_RANGE) ? v : (v - X_RANGE);
  endfunction

  // Saturating score increment.
  function automatic logic [9:0] score_inc(input logic [9:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : (s + 10'd1);
  endfunction

  // Power-on floor layout; slot 0 sits under the slime spawn point.
  function automatic logic [9:0] reset_x(input logic [2:0] n);
    case (n)
      3'd0:    return 10'd300;
      3'd1:    return 10'd120;
      3'd2:    return 10'd460;
      3'd3:    return 10'd40;
      3'd4:    return 10'd380;
      3'd5:    return 10'd220;
      3'd6:    return 10'd520;
      default: return 10'd160;
    endcase
  endfunction

  // Slot N starts at y = 380 - 50*N.
  function automatic logic [9:0] reset_y(input logic [2:0] n);
    case (n)
      3'd0:    return 10'd380;
      3'd1:    return 10'd330;
      3'd2:    return 10'd280;
      3'd3:    return 10'd230;
      3'd4:    return 10'd180;
      3'd5:    return 10'd130;
      3'd6:    return 10'd80;
      default: return 10'd30;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic [9:0] score_q, score_d;
  logic       go_q, go_d;
  logic [7:0] en_q, en_d;
  logic [9:0] x_q [8];
  logic [9:0] x_d [8];
  logic [9:0] y_q [8];
  logic [9:0] y_d [8];
  logic [9:0] min_y;
  logic [9:0] lfsr_nxt;
  logic       tick_scroll;
  logic       tick_die;

  assign lfsr_nxt    = lfsr_step(lfsr_q);
  assign tick_die    = clk_vga && slime_die;
  assign tick_scroll = clk_vga && !slime_die && hit_ceiling;

  // Smallest y among live slots, from registered positions (479 if none live).
  always_comb begin
    min_y = Y_HOLD;
    for (int n = 0; n < 8; n++) begin
      if (en_q[n] && (y_q[n] < min_y)) min_y = y_q[n];
    end
  end

  // FSM state register; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PLAY;
    else     state_q <= state_d;
  end

  // FSM next-state: ticks only matter in PLAY, DEAD is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY: begin
        if (tick_die)         state_d = DEAD;
        else if (tick_scroll) state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == 3'd7) state_d = PLAY;
      end
      DEAD:    state_d = DEAD;
      default: state_d = PLAY;
    endcase
  end

  // FSM outputs: scroll/retire floors in PLAY, respawn one empty slot in SCAN.
  always_comb begin
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    score_d = score_q;
    go_d    = go_q;
    en_d    = en_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      PLAY: begin
        if (tick_die) begin
          go_d = 1'b1;
        end else if (tick_scroll) begin
          idx_d = 3'd0;
          for (int n = 0; n < 8; n++) begin
            if (en_q[n]) begin
              // y <= 479 while live, so y+1 cannot overflow 10 bits
              if ((y_q[n] + 10'd1) >= Y_LIMIT) begin
                en_d[n] = 1'b0;
                y_d[n]  = Y_HOLD;
              end else begin
                y_d[n]  = y_q[n] + 10'd1;
              end
            end
          end
        end
      end
      SCAN: begin
        idx_d = idx_q + 3'd1;
        // After a respawn min_y drops to 0, so later indices of this sweep skip
        if (!en_q[idx_q] && (min_y >= SPAWN_GAP)) begin
          x_d[idx_q]  = fold_x(lfsr_nxt);
          y_d[idx_q]  = 10'd0;
          en_d[idx_q] = 1'b1;
          score_d     = score_inc(score_q);
          lfsr_d      = lfsr_nxt;
        end
      end
      default: begin
        go_d = 1'b1;
      end
    endcase
  end

  // Datapath registers with the power-on floor layout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 3'd0;
      lfsr_q  <= LFSR_SEED;
      score_q <= 10'd0;
      go_q    <= 1'b0;
      en_q    <= 8'hFF;
      for (int n = 0; n < 8; n++) begin
        x_q[n] <= reset_x(3'(n));
        y_q[n] <= reset_y(3'(n));
      end
    end else begin
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      go_q    <= go_d;
      en_q    <= en_d;
      for (int n = 0; n < 8; n++) begin
        x_q[n] <= x_d[n];
        y_q[n] <= y_d[n];
      end
    end
  end

  assign floor_pos_x0 = x_q[0];
  assign floor_pos_x1 = x_q[1];
  assign floor_pos_x2 = x_q[2];
  assign floor_pos_x3 = x_q[3];
  assign floor_pos_x4 = x_q[4];
  assign floor_pos_x5 = x_q[5];
  assign floor_pos_x6 = x_q[6];
  assign floor_pos_x7 = x_q[7];
  assign floor_pos_y0 = y_q[0];
  assign floor_pos_y1 = y_q[1];
  assign floor_pos_y2 = y_q[2];
  assign floor_pos_y3 = y_q[3];
  assign floor_pos_y4 = y_q[4];
  assign floor_pos_y5 = y_q[5];
  assign floor_pos_y6 = y_q[6];
  assign floor_pos_y7 = y_q[7];
  assign enable       = en_q;
  assign score        = score_q;
  assign game_over    = go_q;

endmodule

// File: tb/tb_floor_scheduler.sv
// Testbench for floor_scheduler: hand-computed vector table plus directed
// sequences for scan timing, respawn, death, and asynchronous reset.
module tb_floor_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_vga = 1'b0;
  logic hit_ceiling = 1'b0;
  logic slime_die = 1'b0;
  logic [9:0] dx [8];
  logic [9:0] dy [8];
  logic [7:0] enable;
  logic [9:0] score;
  logic       game_over;

  floor_scheduler dut (
    .clk(clk), .rst(rst), .clk_vga(clk_vga),
    .hit_ceiling(hit_ceiling), .slime_die(slime_die),
    .floor_pos_x0(dx[0]), .floor_pos_x1(dx[1]), .floor_pos_x2(dx[2]), .floor_pos_x3(dx[3]),
    .floor_pos_x4(dx[4]), .floor_pos_x5(dx[5]), .floor_pos_x6(dx[6]), .floor_pos_x7(dx[7]),
    .floor_pos_y0(dy[0]), .floor_pos_y1(dy[1]), .floor_pos_y2(dy[2]), .floor_pos_y3(dy[3]),
    .floor_pos_y4(dy[4]), .floor_pos_y5(dy[5]), .floor_pos_y6(dy[6]), .floor_pos_y7(dy[7]),
    .enable(enable), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  const int RX [8] = '{300, 120, 460, 40, 380, 220, 520, 160};
  const int RY [8] = '{380, 330, 280, 230, 180, 130, 80, 30};

  // Reference model of the floor field, advanced per tick and per sweep.
  int         mx [8];
  int         my [8];
  logic [7:0] men;
  int         mscore;
  logic [9:0] mlfsr;
  int         mgo;

  typedef struct {
    bit tk; bit hit; bit die;
    int y0; int y7; int en; int sc; int go;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int n = 0; n < 8; n++) begin
      mx[n] = RX[n];
      my[n] = RY[n];
    end
    men = 8'hFF; mscore = 0; mlfsr = 10'h2A5; mgo = 0;
  endtask

  task automatic m_scroll();
    for (int n = 0; n < 8; n++) begin
      if (men[n]) begin
        if (my[n] + 1 >= 480) begin
          men[n] = 1'b0;
          my[n] = 479;
        end else begin
          my[n] = my[n] + 1;
        end
      end
    end
  endtask

  task automatic m_scan();
    int mn;
    for (int i = 0; i < 8; i++) begin
      mn = 479;
      for (int n = 0; n < 8; n++) if (men[n] && my[n] < mn) mn = my[n];
      if (!men[i] && mn >= 50) begin
        mlfsr = {mlfsr[8:0], mlfsr[9] ^ mlfsr[6]};
        mx[i] = (mlfsr < 10'd580) ? int'(mlfsr) : int'(mlfsr) - 580;
        my[i] = 0;
        men[i] = 1'b1;
        if (mscore < 999) mscore++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s_x%0d", tag, n), int'(dx[n]), mx[n]);
      chk($sformatf("%s_y%0d", tag, n), int'(dy[n]), my[n]);
    end
    chk({tag, "_en"}, int'(enable), int'(men));
    chk({tag, "_score"}, int'(score), mscore);
    chk({tag, "_go"}, int'(game_over), mgo);
  endtask

  // Called at a falling edge; the tick is sampled by the next rising edge.
  task automatic tick(input bit h, input bit d);
    clk_vga = 1'b1; hit_ceiling = h; slime_die = d;
    @(negedge clk);
    clk_vga = 1'b0; hit_ceiling = 1'b0; slime_die = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    vt[0] = '{tk:1, hit:0, die:0, y0:380, y7:30, en:8'hFF, sc:0, go:0};
    vt[1] = '{tk:1, hit:1, die:0, y0:381, y7:31, en:8'hFF, sc:0, go:0};
    vt[2] = '{tk:0, hit:1, die:0, y0:381, y7:31, en:8'hFF, sc:0, go:0};
    vt[3] = '{tk:1, hit:1, die:0, y0:382, y7:32, en:8'hFF, sc:0, go:0};
    vt[4] = '{tk:1, hit:0, die:0, y0:382, y7:32, en:8'hFF, sc:0, go:0};
    vt[5] = '{tk:1, hit:1, die:0, y0:383, y7:33, en:8'hFF, sc:0, go:0};

    // Reset layout
    do_reset();
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("rst_x%0d", n), int'(dx[n]), RX[n]);
      chk($sformatf("rst_y%0d", n), int'(dy[n]), RY[n]);
    end
    chk("rst_en", int'(enable), 8'hFF);
    chk("rst_score", int'(score), 0);
    chk("rst_go", int'(game_over), 0);

    // One scroll tick, then PLAY again exactly 8 clk later
    tick(1'b1, 1'b0);
    for (int n = 0; n < 8; n++) chk($sformatf("scroll1_y%0d", n), int'(dy[n]), RY[n] + 1);
    wait_n(8);
    chk("scroll1_en", int'(enable), 8'hFF);
    chk("scroll1_score", int'(score), 0);
    tick(1'b1, 1'b0);
    chk("replay_y0", int'(dy[0]), 382);

    // Vector table
    do_reset();
    for (int v = 0; v < 6; v++) begin
      if (vt[v].tk) begin
        tick(vt[v].hit, vt[v].die);
      end else begin
        hit_ceiling = vt[v].hit; slime_die = vt[v].die;
        @(negedge clk);
        hit_ceiling = 1'b0; slime_die = 1'b0;
      end
      wait_n(9);
      chk($sformatf("vec%0d_y0", v), int'(dy[0]), vt[v].y0);
      chk($sformatf("vec%0d_y7", v), int'(dy[7]), vt[v].y7);
      chk($sformatf("vec%0d_en", v), int'(enable), vt[v].en);
      chk($sformatf("vec%0d_score", v), int'(score), vt[v].sc);
      chk($sformatf("vec%0d_go", v), int'(game_over), vt[v].go);
    end

    // Slot 0 runs off the bottom on tick 100, then respawns
    do_reset();
    for (int t = 0; t < 99; t++) begin
      tick(1'b1, 1'b0); m_scroll(); wait_n(9); m_scan();
    end
    chk("t99_y0", int'(dy[0]), 479);
    chk("t99_en", int'(enable), 8'hFF);
    tick(1'b1, 1'b0); m_scroll();
    chk("t100_y0", int'(dy[0]), 479);
    chk("t100_en", int'(enable), 8'hFE);
    wait_n(9); m_scan();
    chk("respawn_x0", int'(dx[0]), 331);
    chk("respawn_y0", int'(dy[0]), 0);
    chk("respawn_score", int'(score), 1);
    chk("respawn_en", int'(enable), 8'hFF);
    check_all("respawn");

    // Tick on the last SCAN cycle is dropped (even with slime_die); next one acts
    tick(1'b1, 1'b0); m_scroll();
    wait_n(7);
    tick(1'b1, 1'b1); m_scan();
    check_all("drop");
    tick(1'b1, 1'b0); m_scroll();
    wait_n(9); m_scan();
    check_all("after_drop");

    // Long run of respawns: spawn x always in range and matching the model
    for (int t = 0; t < 3000; t++) begin
      tick(1'b1, 1'b0); m_scroll(); wait_n(9); m_scan();
      check_all($sformatf("run%0d", t));
      for (int n = 0; n < 8; n++)
        chk($sformatf("run%0d_xrange%0d", t, n), int'(dx[n] <= 10'd579), 1);
    end

    // Death: simultaneous hit and die, then everything frozen
    tick(1'b1, 1'b1); mgo = 1;
    wait_n(9);
    check_all("dead");
    tick(1'b1, 1'b0); wait_n(9);
    tick(1'b0, 1'b1); wait_n(9);
    check_all("dead_hold");
    do_reset();
    check_all("dead_rst");

    // Asynchronous reset in the middle of a sweep
    tick(1'b1, 1'b0); m_scroll();
    wait_n(3);
    chk("pre_arst_y0", int'(dy[0]), 381);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b0); m_scroll();
    wait_n(9); m_scan();
    check_all("post_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
